traffic_lamp_monitor: RTL and testbench
=======================================

Name: traffic_lamp_monitor

Overview:
- Downstream stage of the 3-road traffic light controller.
- Consumes the three per-road state codes, which carry red/yellow/green per road.
- Checks them for safety violations and drives registered one-hot lamp outputs.
- On any violation it latches a fault and flashes all roads red until cleared. It then restarts through an all-red recovery phase.

Parameters:
- MIN_YELLOW, 2: minimum consecutive yellow cycles required before a road goes green.
- FLASH_HALF, 4: cycles per on/off half-period of the fault red flash.
- ALL_RED_TIME, 3: minimum all-red cycles in RECOVER.
- WDOG_CYCLES, 32: maximum cycles allowed between green onsets in NORMAL.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- road1_code  in  4  road 1 code: 0=R, 1=Y, 2=G; anything else invalid
- road2_code  in  4  road 2 code: 3=R, 4=Y, 5=G; anything else invalid
- road3_code  in  4  road 3 code: 6=R, 7=Y, 8=G; anything else invalid
- fault_clr  in  1  operator clear; sampled only in FAULT
- lamp1  out  3  {red,yellow,green}, one-hot or all-off, registered
- lamp2  out  3  same, road 2
- lamp3  out  3  same, road 3
- fault  out  1  high while in FAULT
- fault_cause  out  4  sticky: [0] invalid code, [1] multiple greens, [2] illegal transition/short yellow, [3] watchdog
- state_o  out  2  0=NORMAL, 1=FAULT, 2=RECOVER

Behaviour:
- Reset values: state=RECOVER, lamps=3'b100, fault=0, fault_cause=0, all counters=0, per-road previous colour=RED.
- NORMAL:
  - Each lampN is the registered decode of roadN_code; latency 1 cycle.
  - All checks are evaluated every cycle on the current inputs against the per-road previous colour.
- Checks (NORMAL only):
  - Invalid code on any road -> cause[0].
  - More than one road decoded GREEN -> cause[1].
  - Transition not in {R->R, R->Y, Y->Y, Y->G, G->G, G->R} -> cause[2]. Y->R and R->G are illegal.
  - Y->G with that road's yellow run count < MIN_YELLOW -> cause[2].
  - Watchdog: counts cycles since the last Y->G onset on any road; reaching WDOG_CYCLES -> cause[3]. It resets to 0 on every onset.
- Fault entry:
  - Any check true in cycle t -> state=FAULT at t+1.
  - fault=1 at t+1; fault_cause |= all bits detected in cycle t. Simultaneous causes set simultaneously.
  - The lamp decode of cycle t is suppressed: the lamps at t+1 are the flash pattern.
- FAULT:
  - All lamps 3'b100 for FLASH_HALF cycles, then 3'b000 for FLASH_HALF cycles, repeating. The on phase starts at entry.
  - Inputs are ignored and checks are disabled.
  - fault_clr=1 -> RECOVER next cycle. fault and fault_cause clear on that same edge.
- RECOVER:
  - All lamps 3'b100; a timer counts up.
  - Exit to NORMAL requires both timer ≥ ALL_RED_TIME and a Y->G onset on any road in that cycle. The decoded lamps take effect on the same edge.
  - Per-road previous colour and yellow run counts track the inputs throughout RECOVER, so no false transition fault occurs at exit.
  - The watchdog is cleared on exit.
  - Invalid codes are ignored while in RECOVER.
- Yellow run counter: per road, increments while YELLOW and saturates at MIN_YELLOW; it resets to 0 on any non-yellow cycle.
- fault_clr in NORMAL or RECOVER has no effect.
- Asynchronous reset mid-FAULT or mid-flash returns the block to the reset values immediately.

Decomposition:
- Package traffic_pkg holds:
  - the per-road code constants (0..8);
  - the colour enum {RED, YELLOW, GREEN, INVALID};
  - the lamp encodings LAMP_R=3'b100, LAMP_Y=3'b010, LAMP_G=3'b001, LAMP_OFF=3'b000;
  - the fault-cause bit indices;
  - the monitor state enum.
- Sub-module road_seq_checker, instantiated 3x with per-road base code as a parameter:
  - decodes the code into colour/valid;
  - holds the previous colour and the yellow run counter;
  - flags illegal_trans and green_onset.
- The top level holds the conflict check, watchdog, FSM, flash counter and lamp registers.

Test Plan:
- Normal rotation (R1G 7 cycles, last 2 with R2Y, then R2G, and so on) after a RECOVER exit at the first onset -> lamps mirror inputs 1 cycle late; fault stays 0 for 100 cycles.
- road1_code=2 and road2_code=5 in the same cycle -> next cycle fault=1, cause=4'b0010; lamps read 100 for 4 cycles, then 000 for 4 cycles, repeating.
- Road2 R->G with no yellow -> cause[2]. Separately, road2 Y for 1 cycle then G -> cause[2].
- road3_code=4'd12 plus a double green in the same cycle -> cause=4'b0011.
- Inputs frozen on R1G for 32 cycles after the last onset -> cause[3] asserted; fault_clr pulse -> RECOVER with fault=0, cause=0, all lamps red ≥3 cycles; returns to NORMAL only on the next Y->G.
- rst asserted mid-flash (lamps 000) -> lamps read 100 immediately and state_o=2.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the 3-road traffic lamp monitor: road codes,
// colour and state enums, lamp encodings and fault-cause bit positions.
package traffic_pkg;

    localparam logic [3:0] ROAD1_R = 4'd0;
    localparam logic [3:0] ROAD1_Y = 4'd1;
    localparam logic [3:0] ROAD1_G = 4'd2;
    localparam logic [3:0] ROAD2_R = 4'd3;
    localparam logic [3:0] ROAD2_Y = 4'd4;
    localparam logic [3:0] ROAD2_G = 4'd5;
    localparam logic [3:0] ROAD3_R = 4'd6;
    localparam logic [3:0] ROAD3_Y = 4'd7;
    localparam logic [3:0] ROAD3_G = 4'd8;

    typedef enum logic [1:0] {
        RED     = 2'd0,
        YELLOW  = 2'd1,
        GREEN   = 2'd2,
        INVALID = 2'd3
    } colour_t;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    localparam int CAUSE_INVALID     = 0;
    localparam int CAUSE_MULTI_GREEN = 1;
    localparam int CAUSE_TRANSITION  = 2;
    localparam int CAUSE_WATCHDOG    = 3;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_FAULT   = 2'd1,
        ST_RECOVER = 2'd2
    } mon_state_t;

    function automatic logic [2:0] colour_lamp(input colour_t c);
        case (c)
            RED:     return LAMP_R;
            YELLOW:  return LAMP_Y;
            GREEN:   return LAMP_G;
            default: return LAMP_OFF;
        endcase
    endfunction

endpackage

// File: rtl/road_seq_checker.sv
// Per-road decoder and sequence checker: tracks the previous colour and the
// yellow run length, and flags illegal transitions and yellow->green onsets.
module road_seq_checker
    import traffic_pkg::*;
#(
    parameter logic [3:0] BASE_CODE  = 4'd0,
    parameter int         MIN_YELLOW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] code,
    input  logic       track,
    output colour_t    colour,
    output logic       valid,
    output logic       illegal_trans,
    output logic       green_onset
);

    localparam int               RUN_W   = $clog2(MIN_YELLOW + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MIN_YELLOW);

    colour_t          prev_reg, prev_next;
    logic [RUN_W-1:0] run_reg, run_next;
    logic             trans_ok;

    // Codes of every road are laid out as base+{0,1,2} for R/Y/G.
    always_comb begin
        colour = INVALID;
        if (code == BASE_CODE)
            colour = RED;
        else if (code == BASE_CODE + (ROAD1_Y - ROAD1_R))
            colour = YELLOW;
        else if (code == BASE_CODE + (ROAD1_G - ROAD1_R))
            colour = GREEN;
    end

    assign valid = (colour != INVALID);

    always_comb begin
        trans_ok = 1'b0;
        case (prev_reg)
            RED:     trans_ok = (colour == RED)    || (colour == YELLOW);
            YELLOW:  trans_ok = (colour == YELLOW) || (colour == GREEN);
            GREEN:   trans_ok = (colour == GREEN)  || (colour == RED);
            default: trans_ok = 1'b0;
        endcase
    end

    assign green_onset   = (prev_reg == YELLOW) && (colour == GREEN);
    assign illegal_trans = valid && (!trans_ok || (green_onset && (run_reg < RUN_MAX)));

    // Invalid codes leave the history untouched so a glitch cannot fake a legal sequence.
    always_comb begin
        prev_next = prev_reg;
        run_next  = run_reg;
        if (track && valid) begin
            prev_next = colour;
            if (colour == YELLOW)
                run_next = (run_reg == RUN_MAX) ? run_reg : run_reg + 1'b1;
            else
                run_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_reg <= RED;
            run_reg  <= '0;
        end else begin
            prev_reg <= prev_next;
            run_reg  <= run_next;
        end
    end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Safety monitor behind the 3-road light controller: registered lamp decode,
// conflict/sequence/watchdog checks, latched fault with red flash, all-red recovery.
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW   = 2,
    parameter int FLASH_HALF   = 4,
    parameter int ALL_RED_TIME = 3,
    parameter int WDOG_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] road1_code,
    input  logic [3:0] road2_code,
    input  logic [3:0] road3_code,
    input  logic       fault_clr,
    output logic [2:0] lamp1,
    output logic [2:0] lamp2,
    output logic [2:0] lamp3,
    output logic       fault,
    output logic [3:0] fault_cause,
    output logic [1:0] state_o
);

    localparam int FLASH_PERIOD = 2 * FLASH_HALF;
    localparam int FLASH_W      = $clog2(FLASH_PERIOD);
    localparam int REC_W        = $clog2(ALL_RED_TIME + 1);
    localparam int WDOG_W       = $clog2(WDOG_CYCLES);

    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_PERIOD - 1);
    localparam logic [FLASH_W-1:0] FLASH_ON   = FLASH_W'(FLASH_HALF);
    localparam logic [REC_W-1:0]   REC_MIN    = REC_W'(ALL_RED_TIME);
    localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(WDOG_CYCLES - 1);

    logic [3:0]         road_code [3];
    colour_t            road_colour [3];
    logic [2:0]         road_valid, road_illegal, road_onset, is_green;
    logic [2:0][2:0]    decoded;
    logic               track, any_onset, multi_green;
    logic [3:0]         detect;

    mon_state_t         state_reg, state_next;
    logic [2:0][2:0]    lamp_reg, lamp_next;
    logic [3:0]         cause_reg, cause_next;
    logic [WDOG_W-1:0]  wdog_reg, wdog_next;
    logic [FLASH_W-1:0] flash_reg, flash_next;
    logic [REC_W-1:0]   rec_reg, rec_next;

    assign road_code[0] = road1_code;
    assign road_code[1] = road2_code;
    assign road_code[2] = road3_code;

    // History is frozen in FAULT; RECOVER keeps tracking so the exit is seamless.
    assign track = (state_reg != ST_FAULT);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_road
            localparam logic [3:0] BASE = (gi == 0) ? ROAD1_R : (gi == 1) ? ROAD2_R : ROAD3_R;

            road_seq_checker #(
                .BASE_CODE  (BASE),
                .MIN_YELLOW (MIN_YELLOW)
            ) u_checker (
                .clk           (clk),
                .rst           (rst),
                .code          (road_code[gi]),
                .track         (track),
                .colour        (road_colour[gi]),
                .valid         (road_valid[gi]),
                .illegal_trans (road_illegal[gi]),
                .green_onset   (road_onset[gi])
            );

            assign is_green[gi] = (road_colour[gi] == GREEN);
            assign decoded[gi]  = colour_lamp(road_colour[gi]);
        end
    endgenerate

    assign any_onset   = |road_onset;
    assign multi_green = (is_green[0] & is_green[1]) | (is_green[0] & is_green[2]) |
                         (is_green[1] & is_green[2]);

    always_comb begin
        detect                    = '0;
        detect[CAUSE_INVALID]     = ~&road_valid;
        detect[CAUSE_MULTI_GREEN] = multi_green;
        detect[CAUSE_TRANSITION]  = |road_illegal;
        detect[CAUSE_WATCHDOG]    = (wdog_reg == WDOG_LAST) && !any_onset;
    end

    always_comb begin
        state_next = state_reg;
        lamp_next  = lamp_reg;
        cause_next = cause_reg;
        wdog_next  = wdog_reg;
        flash_next = flash_reg;
        rec_next   = rec_reg;
        case (state_reg)
            ST_NORMAL: begin
                if (|detect) begin
                    state_next = ST_FAULT;
                    cause_next = cause_reg | detect;
                    flash_next = '0;
                    lamp_next  = {3{LAMP_R}};
                end else begin
                    lamp_next = decoded;
                    wdog_next = any_onset ? '0 : wdog_reg + 1'b1;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_next = ST_RECOVER;
                    cause_next = '0;
                    rec_next   = '0;
                    lamp_next  = {3{LAMP_R}};
                end else begin
                    flash_next = (flash_reg == FLASH_LAST) ? '0 : flash_reg + 1'b1;
                    lamp_next  = (flash_next < FLASH_ON) ? {3{LAMP_R}} : {3{LAMP_OFF}};
                end
            end
            ST_RECOVER: begin
                lamp_next = {3{LAMP_R}};
                if ((rec_reg >= REC_MIN) && any_onset) begin
                    state_next = ST_NORMAL;
                    lamp_next  = decoded;
                    wdog_next  = '0;
                end else if (rec_reg < REC_MIN) begin
                    rec_next = rec_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_RECOVER;
                lamp_next  = {3{LAMP_R}};
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RECOVER;
            lamp_reg  <= {3{LAMP_R}};
            cause_reg <= '0;
            wdog_reg  <= '0;
            flash_reg <= '0;
            rec_reg   <= '0;
        end else begin
            state_reg <= state_next;
            lamp_reg  <= lamp_next;
            cause_reg <= cause_next;
            wdog_reg  <= wdog_next;
            flash_reg <= flash_next;
            rec_reg   <= rec_next;
        end
    end

    assign lamp1       = lamp_reg[0];
    assign lamp2       = lamp_reg[1];
    assign lamp3       = lamp_reg[2];
    assign fault       = (state_reg == ST_FAULT);
    assign fault_cause = cause_reg;
    assign state_o     = state_reg;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Scoreboard bench for traffic_lamp_monitor: expected outputs are queued as each
// cycle of stimulus is driven and compared one cycle later.
module tb_traffic_lamp_monitor;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] road1_code = ROAD1_R;
    logic [3:0] road2_code = ROAD2_R;
    logic [3:0] road3_code = ROAD3_R;
    logic       fault_clr = 1'b0;
    logic [2:0] lamp1, lamp2, lamp3;
    logic       fault;
    logic [3:0] fault_cause;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [2:0] l1;
        logic [2:0] l2;
        logic [2:0] l3;
        logic       flt;
        logic [3:0] cause;
        logic [1:0] st;
    } obs_t;

    obs_t exp_q[$];

    traffic_lamp_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .road1_code  (road1_code),
        .road2_code  (road2_code),
        .road3_code  (road3_code),
        .fault_clr   (fault_clr),
        .lamp1       (lamp1),
        .lamp2       (lamp2),
        .lamp3       (lamp3),
        .fault       (fault),
        .fault_cause (fault_cause),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation budget exhausted");
        $fatal(1, "timeout");
    end

    function automatic obs_t mk(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                                input logic f, input logic [3:0] cs, input logic [1:0] s);
        obs_t o;
        o.l1 = a; o.l2 = b; o.l3 = c; o.flt = f; o.cause = cs; o.st = s;
        return o;
    endfunction

    function automatic logic [2:0] lamp_of(input logic [3:0] code, input logic [3:0] base);
        if (code == base)            return 3'b100;
        if (code == base + 4'd1)     return 3'b010;
        if (code == base + 4'd2)     return 3'b001;
        return 3'b000;
    endfunction

    function automatic obs_t norm_exp(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        return mk(lamp_of(a, 4'd0), lamp_of(b, 4'd3), lamp_of(c, 4'd6), 1'b0, 4'b0000, 2'd0);
    endfunction

    function automatic obs_t flash_exp(input int k, input logic [3:0] cs);
        logic [2:0] l;
        l = ((k % 8) < 4) ? 3'b100 : 3'b000;
        return mk(l, l, l, 1'b1, cs, 2'd1);
    endfunction

    function automatic obs_t recover_exp();
        return mk(3'b100, 3'b100, 3'b100, 1'b0, 4'b0000, 2'd2);
    endfunction

    function automatic obs_t sample_dut();
        return mk(lamp1, lamp2, lamp3, fault, fault_cause, state_o);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("lamps=%b/%b/%b fault=%b cause=%b state=%0d", o.l1, o.l2, o.l3, o.flt, o.cause, o.st);
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic clr);
        road1_code = a;
        road2_code = b;
        road3_code = c;
        fault_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        road1_code = ROAD1_R; road2_code = ROAD2_R; road3_code = ROAD3_R; fault_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Leaves the DUT in NORMAL with road 1 green, onset on the last cycle driven.
    task automatic to_normal();
        for (int i = 0; i < 6; i++)
            drive((i < 3) ? ROAD1_R : (i < 5) ? ROAD1_Y : ROAD1_G, ROAD2_R, ROAD3_R, i == 0);
    endtask

    task automatic test_reset();
        obs_t got, exp;
        logic [3:0] a;
        rst = 1'b0;
        #1 rst = 1'b1;
        #3;
        exp_q.push_back(recover_exp());
        got = sample_dut(); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_async: got %s, required %s", fmt(got), fmt(exp));
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a = (i < 3) ? ROAD1_R : (i < 5) ? ROAD1_Y : ROAD1_G;
            exp_q.push_back((i == 5) ? norm_exp(a, ROAD2_R, ROAD3_R) : recover_exp());
            drive(a, ROAD2_R, ROAD3_R, i == 0);
            got = sample_dut(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL recover_exit[%0d]: got %s, required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_rotation();
        obs_t got, exp;
        logic [3:0] c [3];
        logic [3:0] base [3];
        int p, pos;
        base[0] = ROAD1_R; base[1] = ROAD2_R; base[2] = ROAD3_R;
        do_reset();
        to_normal();
        for (int t = 0; t < 100; t++) begin
            p = (t / 7) % 3;
            pos = t % 7;
            for (int r = 0; r < 3; r++) c[r] = base[r];
            c[p] = base[p] + 4'd2;
            if (pos >= 5) c[(p + 1) % 3] = base[(p + 1) % 3] + 4'd1;
            exp_q.push_back(norm_exp(c[0], c[1], c[2]));
            drive(c[0], c[1], c[2], (t % 13) == 5);
            got = sample_dut(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rotation[%0d]: got %s, required %s", t, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_double_green_flash();
        obs_t got, exp;
        do_reset();
        to_normal();
        for (int k = -2; k <= 16; k++) begin
            if (k < 0) begin
                exp_q.push_back(norm_exp(ROAD1_G, ROAD2_Y, ROAD3_R));
                drive(ROAD1_G, ROAD2_Y, ROAD3_R, 1'b0);
            end else if (k == 0) begin
                exp_q.push_back(flash_exp(0, 4'b0010));
                drive(ROAD1_G, ROAD2_G, ROAD3_R, 1'b0);
            end else begin
                exp_q.push_back(flash_exp(k, 4'b0010));
                drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
            end
            got = sample_dut(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL double_green_flash[%0d]: got %s, required %s", k, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_transitions();
        obs_t got, exp;
        for (int cs = 0; cs < 3; cs++) begin
            do_reset();
            to_normal();
            for (int i = 0; i < cs; i++) begin
                exp_q.push_back(norm_exp(ROAD1_G, ROAD2_Y, ROAD3_R));
                drive(ROAD1_G, ROAD2_Y, ROAD3_R, 1'b0);
                got = sample_dut(); exp = exp_q.pop_front(); n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL trans_pre[%0d.%0d]: got %s, required %s", cs, i, fmt(got), fmt(exp));
                end
            end
            exp_q.push_back(flash_exp(0, 4'b0100));
            if (cs == 2) drive(ROAD1_G, ROAD2_R, ROAD3_R, 1'b0);
            else         drive(ROAD1_R, ROAD2_G, ROAD3_R, 1'b0);
            got = sample_dut(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL trans_fault[%0d]: got %s, required %s", cs, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_invalid_code();
        obs_t got, exp;
        for (int cs = 0; cs < 2; cs++) begin
            do_reset();
            to_normal();
            if (cs == 1) begin
                for (int i = 0; i < 2; i++) begin
                    exp_q.push_back(norm_exp(ROAD1_G, ROAD2_Y, ROAD3_R));
                    drive(ROAD1_G, ROAD2_Y, ROAD3_R, 1'b0);
                    got = sample_dut(); exp = exp_q.pop_front(); n_checks++;
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL invalid_pre[%0d]: got %s, required %s", i, fmt(got), fmt(exp));
                    end
                end
            end
            exp_q.push_back(flash_exp(0, (cs == 1) ? 4'b0011 : 4'b0001));
            drive(ROAD1_G, (cs == 1) ? ROAD2_G : ROAD2_R, 4'd12, 1'b0);
            got = sample_dut(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL invalid_fault[%0d]: got %s, required %s", cs, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_watchdog_clear();
        obs_t got, exp;
        logic [3:0] rec_seq [8];
        rec_seq = '{ROAD1_Y, ROAD1_Y, ROAD1_G, ROAD1_G, ROAD1_R, ROAD1_Y, ROAD1_Y, ROAD1_G};
        do_reset();
        to_normal();
        for (int k = 1; k <= 34; k++) begin
            if (k < 32)       exp_q.push_back(norm_exp(ROAD1_G, ROAD2_R, ROAD3_R));
            else              exp_q.push_back(flash_exp(k - 32, 4'b1000));
            drive(ROAD1_G, ROAD2_R, ROAD3_R, 1'b0);
            got = sample_dut(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL watchdog[%0d]: got %s, required %s", k, fmt(got), fmt(exp));
            end
        end
        exp_q.push_back(recover_exp());
        drive(ROAD1_G, ROAD2_R, ROAD3_R, 1'b1);
        got = sample_dut(); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL fault_clear: got %s, required %s", fmt(got), fmt(exp));
        end
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back((i == 7) ? norm_exp(ROAD1_G, ROAD2_R, ROAD3_R) : recover_exp());
            drive(rec_seq[i], ROAD2_R, ROAD3_R, 1'b0);
            got = sample_dut(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL recover_after_clear[%0d]: got %s, required %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_reset_mid_flash();
        obs_t got, exp;
        do_reset();
        to_normal();
        for (int k = -2; k <= 5; k++) begin
            if (k < 0) begin
                exp_q.push_back(norm_exp(ROAD1_G, ROAD2_Y, ROAD3_R));
                drive(ROAD1_G, ROAD2_Y, ROAD3_R, 1'b0);
            end else begin
                exp_q.push_back(flash_exp(k, 4'b0010));
                drive(ROAD1_G, ROAD2_G, ROAD3_R, 1'b0);
            end
            got = sample_dut(); exp = exp_q.pop_front(); n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL pre_reset_flash[%0d]: got %s, required %s", k, fmt(got), fmt(exp));
            end
        end
        #2 rst = 1'b1;
        #1;
        exp_q.push_back(recover_exp());
        got = sample_dut(); exp = exp_q.pop_front(); n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_flash: got %s, required %s", fmt(got), fmt(exp));
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_double_green_flash();
        test_transitions();
        test_invalid_code();
        test_watchdog_clear();
        test_reset_mid_flash();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
